// File: rtl/mem_access.sv
// MEM pipeline stage: req/ack data-bus access with load alignment/extension and store byte enables.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_waddr,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_ld_type,
    input  logic [31:0] mem_read_addr,
    input  logic        mem_ram_wreg,
    input  logic [31:0] mem_ram_waddr,
    input  logic [31:0] mem_ram_wdata,
    input  logic [1:0]  mem_st_type,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        stall_req,
    output logic [4:0]  wb_waddr,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        bus_err,
    output logic        misalign_exc
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic [31:0] r_ld_result;
    logic        r_req, r_we, r_bus_err;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;

    logic        w_access, w_is_load, w_misalign, w_timeout;
    logic [31:0] w_acc_addr, w_ld_fmt, w_st_wdata;
    logic [3:0]  w_st_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // A store wins when both a load and a store are flagged.
    assign w_access   = (mem_ld_type != 3'b111) || mem_ram_wreg;
    assign w_is_load  = (mem_ld_type != 3'b111) && !mem_ram_wreg;
    assign w_acc_addr = mem_ram_wreg ? mem_ram_waddr : mem_read_addr;
    assign w_timeout  = (r_cnt == 16'(BUS_TIMEOUT - 1));

    always_comb begin
        w_byte = dbus_rdata[{mem_read_addr[1:0], 3'b000} +: 8];
        w_half = mem_read_addr[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (mem_ld_type)
            3'b000:  w_ld_fmt = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_fmt = {24'd0, w_byte};
            3'b001:  w_ld_fmt = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_fmt = {16'd0, w_half};
            default: w_ld_fmt = dbus_rdata;
        endcase
    end

    always_comb begin
        case (mem_st_type)
            2'b00: begin
                w_st_be    = 4'b0001 << mem_ram_waddr[1:0];
                w_st_wdata = {4{mem_ram_wdata[7:0]}};
            end
            2'b01: begin
                w_st_be    = mem_ram_waddr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{mem_ram_wdata[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = mem_ram_wdata;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        if (mem_ram_wreg) begin
            if (mem_st_type == 2'b01)      w_misalign = mem_ram_waddr[0];
            else if (mem_st_type != 2'b00) w_misalign = (mem_ram_waddr[1:0] != 2'b00);
        end else if (mem_ld_type != 3'b111) begin
            if (mem_ld_type == 3'b001 || mem_ld_type == 3'b101)
                w_misalign = mem_read_addr[0];
            else if (mem_ld_type != 3'b000 && mem_ld_type != 3'b100)
                w_misalign = (mem_read_addr[1:0] != 2'b00);
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_access && !w_misalign) w_next = S_ACCESS;
            S_ACCESS: if (dbus_ack || w_timeout) w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_bus_err   <= 1'b0;
            r_ld_result <= '0;
        end else begin
            r_state   <= w_next;
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: if (w_access && !w_misalign) begin
                    r_req   <= 1'b1;
                    r_we    <= mem_ram_wreg;
                    r_addr  <= {w_acc_addr[31:2], 2'b00};
                    r_be    <= mem_ram_wreg ? w_st_be : 4'b1111;
                    r_wdata <= mem_ram_wreg ? w_st_wdata : 32'd0;
                    r_cnt   <= '0;
                end
                S_ACCESS: begin
                    if (dbus_ack) begin
                        r_ld_result <= w_ld_fmt;
                        r_req       <= 1'b0;
                        r_cnt       <= '0;
                    end else if (w_timeout) begin
                        r_ld_result <= '0;
                        r_req       <= 1'b0;
                        r_bus_err   <= 1'b1;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbus_req   = r_req;
    assign dbus_we    = r_we;
    assign dbus_addr  = r_addr;
    assign dbus_be    = r_be;
    assign dbus_wdata = r_wdata;
    assign bus_err    = r_bus_err;

    always_comb begin
        stall_req    = 1'b0;
        misalign_exc = 1'b0;
        wb_waddr     = mem_waddr;
        wb_wreg      = mem_wreg;
        wb_wdata     = mem_wdata;
        if (!rst) begin
            wb_waddr = '0;
            wb_wreg  = 1'b0;
            wb_wdata = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_misalign) begin
                        misalign_exc = 1'b1;
                        wb_wreg      = 1'b0;
                    end else if (w_access) begin
                        stall_req = 1'b1;
                        wb_wreg   = 1'b0;
                    end
                end
                S_ACCESS: begin
                    stall_req = 1'b1;
                    wb_wreg   = 1'b0;
                end
                default: begin
                    if (w_is_load) wb_wdata = r_ld_result;
                    else           wb_wreg  = 1'b0;
                end
            endcase
        end
    end
endmodule
